// File: rtl/fft_pkg.sv
// Shared constants for the radix-2 FFT datapath: default widths, rounding
// constant and output saturation bounds for the default output width.
package fft_pkg;

    localparam int unsigned Q_IN_DEF   = 15;
    localparam int unsigned Q_COEF_DEF = 15;
    localparam int unsigned Q_OUT_DEF  = 15;

    function automatic longint pow2(input int unsigned e);
        return 64'sd1 <<< e;
    endfunction

    localparam longint ROUND_HALF = pow2(Q_COEF_DEF - 1);
    localparam longint SAT_MAX    = pow2(Q_OUT_DEF) - 64'sd1;
    localparam longint SAT_MIN    = -pow2(Q_OUT_DEF);

endpackage

// File: rtl/fft_cmul_round.sv
// Pipelined complex multiply t = W*b, rounded half-up back to sample scale.
// Two register stages; operand a travels alongside so it lines up with t.
module fft_cmul_round
    import fft_pkg::*;
#(
    parameter int unsigned Q_IN   = Q_IN_DEF,
    parameter int unsigned Q_COEF = Q_COEF_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_valid,
    input  logic signed [Q_IN:0]     i_a_re,
    input  logic signed [Q_IN:0]     i_a_im,
    input  logic signed [Q_IN:0]     i_b_re,
    input  logic signed [Q_IN:0]     i_b_im,
    input  logic signed [Q_COEF:0]   i_w_re,
    input  logic signed [Q_COEF:0]   i_w_im,
    output logic                     o_valid,
    output logic signed [Q_IN:0]     o_a_re,
    output logic signed [Q_IN:0]     o_a_im,
    output logic signed [Q_IN+2:0]   o_t_re,
    output logic signed [Q_IN+2:0]   o_t_im
);

    localparam int unsigned WP  = Q_IN + Q_COEF + 2;
    localparam int unsigned WE  = WP + 1;
    localparam int unsigned WT  = Q_IN + 3;
    localparam longint      RND = (Q_COEF == Q_COEF_DEF) ? ROUND_HALF : pow2(Q_COEF - 1);

    logic signed [WP-1:0] w_p_rr, w_p_ii, w_p_ri, w_p_ir;
    logic signed [WE-1:0] w_tr, w_ti;
    logic signed [WT-1:0] w_tr_q, w_ti_q;

    logic                 r_v1, r_v2;
    logic signed [Q_IN:0] r_a_re1, r_a_im1, r_a_re2, r_a_im2;
    logic signed [WP-1:0] r_p_rr, r_p_ii, r_p_ri, r_p_ir;
    logic signed [WT-1:0] r_t_re, r_t_im;

    // Products from the raw inputs; cross terms combined and rounded from the product registers.
    always_comb begin
        w_p_rr = WP'(i_b_re) * WP'(i_w_re);
        w_p_ii = WP'(i_b_im) * WP'(i_w_im);
        w_p_ri = WP'(i_b_re) * WP'(i_w_im);
        w_p_ir = WP'(i_b_im) * WP'(i_w_re);
        w_tr   = WE'(r_p_rr) - WE'(r_p_ii) + WE'(RND);
        w_ti   = WE'(r_p_ri) + WE'(r_p_ir) + WE'(RND);
        w_tr_q = WT'(w_tr >>> Q_COEF);
        w_ti_q = WT'(w_ti >>> Q_COEF);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_a_re1 <= '0;
            r_a_im1 <= '0;
            r_a_re2 <= '0;
            r_a_im2 <= '0;
            r_p_rr  <= '0;
            r_p_ii  <= '0;
            r_p_ri  <= '0;
            r_p_ir  <= '0;
            r_t_re  <= '0;
            r_t_im  <= '0;
        end else begin
            r_v1 <= i_valid;
            r_v2 <= r_v1;
            if (i_valid) begin
                r_a_re1 <= i_a_re;
                r_a_im1 <= i_a_im;
                r_p_rr  <= w_p_rr;
                r_p_ii  <= w_p_ii;
                r_p_ri  <= w_p_ri;
                r_p_ir  <= w_p_ir;
            end
            if (r_v1) begin
                r_a_re2 <= r_a_re1;
                r_a_im2 <= r_a_im1;
                r_t_re  <= w_tr_q;
                r_t_im  <= w_ti_q;
            end
        end
    end

    assign o_valid = r_v2;
    assign o_a_re  = r_a_re2;
    assign o_a_im  = r_a_im2;
    assign o_t_re  = r_t_re;
    assign o_t_im  = r_t_im;

endmodule

// File: rtl/fft_butterfly_r2.sv
// Radix-2 DIT butterfly: out0 = a + W*b, out1 = a - W*b, optional halving,
// saturation with a sticky flag, and a per-frame pair counter.
module fft_butterfly_r2
    import fft_pkg::*;
#(
    parameter int unsigned Q_IN   = Q_IN_DEF,
    parameter int unsigned Q_COEF = Q_COEF_DEF,
    parameter int unsigned Q_OUT  = Q_OUT_DEF,
    parameter int unsigned N      = 256,
    parameter int unsigned SCALE  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid_in,
    input  logic signed [Q_IN:0]    data_in_real_0,
    input  logic signed [Q_IN:0]    data_in_imag_0,
    input  logic signed [Q_IN:0]    data_in_real_1,
    input  logic signed [Q_IN:0]    data_in_imag_1,
    input  logic signed [Q_COEF:0]  coeff_in_real,
    input  logic signed [Q_COEF:0]  coeff_in_imag,
    output logic                    valid_out,
    output logic signed [Q_OUT:0]   data_out_real_0,
    output logic signed [Q_OUT:0]   data_out_imag_0,
    output logic signed [Q_OUT:0]   data_out_real_1,
    output logic signed [Q_OUT:0]   data_out_imag_1,
    output logic                    frame_done,
    output logic                    sat_flag
);

    localparam int unsigned WS     = Q_IN + 1;
    localparam int unsigned WT     = Q_IN + 3;
    localparam int unsigned WSUM   = Q_IN + 4;
    localparam int unsigned WO     = Q_OUT + 1;
    localparam int unsigned PAIRS  = N / 2;
    localparam int unsigned CW     = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam longint      SAT_HI = (Q_OUT == Q_OUT_DEF) ? SAT_MAX : pow2(Q_OUT) - 64'sd1;
    localparam longint      SAT_LO = (Q_OUT == Q_OUT_DEF) ? SAT_MIN : -pow2(Q_OUT);
    localparam logic signed [WSUM-1:0] HI_S = WSUM'(SAT_HI);
    localparam logic signed [WSUM-1:0] LO_S = WSUM'(SAT_LO);

    function automatic logic signed [WSUM-1:0] scale_f(input logic signed [WSUM-1:0] x);
        return (SCALE != 0) ? (x >>> 1) : x;
    endfunction

    function automatic logic signed [WO-1:0] sat_f(input logic signed [WSUM-1:0] x);
        if (x > HI_S) return WO'(HI_S);
        if (x < LO_S) return WO'(LO_S);
        return WO'(x);
    endfunction

    function automatic logic hit_f(input logic signed [WSUM-1:0] x);
        return (x > HI_S) || (x < LO_S);
    endfunction

    logic                   r_in_valid;
    logic signed [WS-1:0]   r_a_re, r_a_im, r_b_re, r_b_im;
    logic signed [Q_COEF:0] r_w_re, r_w_im;

    logic                   w_valid;
    logic signed [WS-1:0]   w_a_re, w_a_im;
    logic signed [WT-1:0]   w_t_re, w_t_im;
    logic signed [WSUM-1:0] w_s_re, w_s_im, w_d_re, w_d_im;
    logic signed [WO-1:0]   w_o0_re, w_o0_im, w_o1_re, w_o1_im;
    logic                   w_hit;

    logic                   r_valid_out, r_frame_done, r_sat;
    logic signed [WO-1:0]   r_o0_re, r_o0_im, r_o1_re, r_o1_im;
    logic [CW-1:0]          r_cnt;

    // Input capture so the multiplier sees registered operands.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_in_valid <= 1'b0;
            r_a_re     <= '0;
            r_a_im     <= '0;
            r_b_re     <= '0;
            r_b_im     <= '0;
            r_w_re     <= '0;
            r_w_im     <= '0;
        end else begin
            r_in_valid <= valid_in;
            if (valid_in) begin
                r_a_re <= data_in_real_0;
                r_a_im <= data_in_imag_0;
                r_b_re <= data_in_real_1;
                r_b_im <= data_in_imag_1;
                r_w_re <= coeff_in_real;
                r_w_im <= coeff_in_imag;
            end
        end
    end

    fft_cmul_round #(
        .Q_IN   (Q_IN),
        .Q_COEF (Q_COEF)
    ) u_cmul (
        .clk     (clk),
        .reset   (reset),
        .i_valid (r_in_valid),
        .i_a_re  (r_a_re),
        .i_a_im  (r_a_im),
        .i_b_re  (r_b_re),
        .i_b_im  (r_b_im),
        .i_w_re  (r_w_re),
        .i_w_im  (r_w_im),
        .o_valid (w_valid),
        .o_a_re  (w_a_re),
        .o_a_im  (w_a_im),
        .o_t_re  (w_t_re),
        .o_t_im  (w_t_im)
    );

    // Sum/difference, optional halving, clamp to the output range.
    always_comb begin
        w_s_re  = scale_f(WSUM'(w_a_re) + WSUM'(w_t_re));
        w_s_im  = scale_f(WSUM'(w_a_im) + WSUM'(w_t_im));
        w_d_re  = scale_f(WSUM'(w_a_re) - WSUM'(w_t_re));
        w_d_im  = scale_f(WSUM'(w_a_im) - WSUM'(w_t_im));
        w_o0_re = sat_f(w_s_re);
        w_o0_im = sat_f(w_s_im);
        w_o1_re = sat_f(w_d_re);
        w_o1_im = sat_f(w_d_im);
        w_hit   = hit_f(w_s_re) | hit_f(w_s_im) | hit_f(w_d_re) | hit_f(w_d_im);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid_out  <= 1'b0;
            r_frame_done <= 1'b0;
            r_sat        <= 1'b0;
            r_cnt        <= '0;
            r_o0_re      <= '0;
            r_o0_im      <= '0;
            r_o1_re      <= '0;
            r_o1_im      <= '0;
        end else begin
            r_valid_out  <= w_valid;
            r_frame_done <= 1'b0;
            if (w_valid) begin
                r_o0_re <= w_o0_re;
                r_o0_im <= w_o0_im;
                r_o1_re <= w_o1_re;
                r_o1_im <= w_o1_im;
                r_sat   <= r_sat | w_hit;
                if (r_cnt == CW'(PAIRS - 1)) begin
                    r_cnt        <= '0;
                    r_frame_done <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign valid_out       = r_valid_out;
    assign data_out_real_0 = r_o0_re;
    assign data_out_imag_0 = r_o0_im;
    assign data_out_real_1 = r_o1_re;
    assign data_out_imag_1 = r_o1_im;
    assign frame_done      = r_frame_done;
    assign sat_flag        = r_sat;

endmodule

// File: tb/tb_fft_butterfly_r2.sv
// Directed bench for fft_butterfly_r2: hand-computed vector table on a scaled
// and an unscaled instance, plus frame counting and reset-in-flight sequences.
module tb_fft_butterfly_r2;

    logic clk = 1'b0;
    logic reset;
    logic vin1, vin0;
    logic signed [15:0] ar, ai, br, bi, wr, wi;

    logic               o1_v, o1_fd, o1_sat;
    logic signed [15:0] o1_r0, o1_i0, o1_r1, o1_i1;
    logic               o0_v, o0_fd, o0_sat;
    logic signed [15:0] o0_r0, o0_i0, o0_r1, o0_i1;

    int total = 0;
    int bad   = 0;
    int prev_sat [2];
    logic [63:0] last_exp;

    typedef struct {
        int sel;
        int ar; int ai; int br; int bi; int wr; int wi;
        int e0r; int e0i; int e1r; int e1i;
        int esat;
    } vec_t;

    vec_t vecs [10];

    always #5 clk = ~clk;

    fft_butterfly_r2 #(.N(256), .SCALE(1)) u_dut1 (
        .clk(clk), .reset(reset), .valid_in(vin1),
        .data_in_real_0(ar), .data_in_imag_0(ai),
        .data_in_real_1(br), .data_in_imag_1(bi),
        .coeff_in_real(wr), .coeff_in_imag(wi),
        .valid_out(o1_v),
        .data_out_real_0(o1_r0), .data_out_imag_0(o1_i0),
        .data_out_real_1(o1_r1), .data_out_imag_1(o1_i1),
        .frame_done(o1_fd), .sat_flag(o1_sat)
    );

    fft_butterfly_r2 #(.N(256), .SCALE(0)) u_dut0 (
        .clk(clk), .reset(reset), .valid_in(vin0),
        .data_in_real_0(ar), .data_in_imag_0(ai),
        .data_in_real_1(br), .data_in_imag_1(bi),
        .coeff_in_real(wr), .coeff_in_imag(wi),
        .valid_out(o0_v),
        .data_out_real_0(o0_r0), .data_out_imag_0(o0_i0),
        .data_out_real_1(o0_r1), .data_out_imag_1(o0_i1),
        .frame_done(o0_fd), .sat_flag(o0_sat)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rnd16();
        return int'($urandom_range(65535, 0)) - 32768;
    endfunction

    task automatic drive(input int a_r, input int a_i, input int b_r, input int b_i,
                         input int w_r, input int w_i);
        ar = 16'(a_r); ai = 16'(a_i);
        br = 16'(b_r); bi = 16'(b_i);
        wr = 16'(w_r); wi = 16'(w_i);
    endtask

    task automatic drive_rnd();
        drive(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16());
    endtask

    task automatic sample(input int sel, output int vo, output int r0, output int i0,
                          output int r1, output int i1, output int fd, output int sat);
        if (sel == 1) begin
            vo = int'(o1_v); fd = int'(o1_fd); sat = int'(o1_sat);
            r0 = int'(o1_r0); i0 = int'(o1_i0); r1 = int'(o1_r1); i1 = int'(o1_i1);
        end else begin
            vo = int'(o0_v); fd = int'(o0_fd); sat = int'(o0_sat);
            r0 = int'(o0_r0); i0 = int'(o0_i0); r1 = int'(o0_r1); i1 = int'(o0_i1);
        end
    endtask

    function automatic longint clamp(input longint x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    // Reference butterfly in plain integer arithmetic.
    function automatic logic [63:0] model(input int scale, input int a_r, input int a_i,
                                          input int b_r, input int b_i,
                                          input int w_r, input int w_i);
        longint tr, ti, sr, si, dr, di;
        tr = longint'(b_r) * w_r - longint'(b_i) * w_i;
        ti = longint'(b_r) * w_i + longint'(b_i) * w_r;
        tr = (tr + 16384) >>> 15;
        ti = (ti + 16384) >>> 15;
        sr = a_r + tr; si = a_i + ti;
        dr = a_r - tr; di = a_i - ti;
        if (scale != 0) begin
            sr = sr >>> 1; si = si >>> 1; dr = dr >>> 1; di = di >>> 1;
        end
        return {16'(clamp(sr)), 16'(clamp(si)), 16'(clamp(dr)), 16'(clamp(di))};
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        int vo, r0, i0, r1, i1, fd, sat;
        drive(v.ar, v.ai, v.br, v.bi, v.wr, v.wi);
        if (v.sel == 1) vin1 = 1'b1; else vin0 = 1'b1;
        tick();
        vin1 = 1'b0;
        vin0 = 1'b0;
        drive_rnd();
        for (int c = 1; c <= 4; c++) begin
            tick();
            sample(v.sel, vo, r0, i0, r1, i1, fd, sat);
            if (c != 3) chk($sformatf("v%0d_valid_c%0d", idx, c), vo, 0);
            if (c == 2) chk($sformatf("v%0d_sat_before", idx), sat, prev_sat[v.sel]);
            if (c == 3) begin
                chk($sformatf("v%0d_valid", idx), vo, 1);
                chk($sformatf("v%0d_out0_re", idx), r0, v.e0r);
                chk($sformatf("v%0d_out0_im", idx), i0, v.e0i);
                chk($sformatf("v%0d_out1_re", idx), r1, v.e1r);
                chk($sformatf("v%0d_out1_im", idx), i1, v.e1i);
                chk($sformatf("v%0d_sat", idx), sat, v.esat);
            end
            if (c == 4) begin
                chk($sformatf("v%0d_hold_out0_re", idx), r0, v.e0r);
                chk($sformatf("v%0d_hold_out1_im", idx), i1, v.e1i);
            end
        end
        prev_sat[v.sel] = v.esat;
    endtask

    // 128 pairs on the scaled instance with (gap) idle cycles between them.
    task automatic run_frame(input int gap, input string tag);
        logic [63:0] q [$];
        logic [63:0] e;
        int sent = 0, got = 0, fd_cnt = 0, fd_at = -1, first = -1, last = -1, cyc = 0;
        while ((sent < 128 || got < sent) && cyc < 2000) begin
            if (sent < 128 && (cyc % (gap + 1)) == 0) begin
                drive_rnd();
                q.push_back(model(1, int'(ar), int'(ai), int'(br), int'(bi), int'(wr), int'(wi)));
                vin1 = 1'b1;
                sent++;
            end else begin
                vin1 = 1'b0;
            end
            tick();
            if (o1_v) begin
                got++;
                if (first < 0) first = cyc;
                last = cyc;
                if (q.size() > 0) begin
                    e = q.pop_front();
                    last_exp = e;
                    chk($sformatf("%s_data%0d", tag, got), longint'({o1_r0, o1_i0, o1_r1, o1_i1}), longint'(e));
                end else begin
                    chk($sformatf("%s_spurious_valid", tag), 1, 0);
                end
            end
            if (o1_fd) begin
                fd_cnt++;
                fd_at = got;
            end
            cyc++;
        end
        vin1 = 1'b0;
        chk($sformatf("%s_outputs", tag), got, 128);
        chk($sformatf("%s_frame_done_count", tag), fd_cnt, 1);
        chk($sformatf("%s_frame_done_at", tag), fd_at, 128);
        if (gap == 0) chk($sformatf("%s_consecutive_span", tag), last - first, 127);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int vo, r0, i0, r1, i1, fd, sat;

        //          sel  ar      ai   br      bi    wr      wi       e0r     e0i   e1r     e1i   sat
        vecs[0] = '{1,   1000,   0,   500,    0,    32767,  0,       750,    0,    250,    0,    0};
        vecs[1] = '{1,   1000,   0,   500,    0,    0,      -32768,  500,    -250, 500,    250,  0};
        vecs[2] = '{1,   -1000,  200, 0,      0,    32767,  0,       -500,   100,  -500,   100,  0};
        vecs[3] = '{1,   -3,     0,   0,      0,    32767,  0,       -2,     0,    -2,     0,    0};
        vecs[4] = '{1,   -32768, 0,   -32768, 0,    -32768, 0,       0,      0,    -32768, 0,    0};
        vecs[5] = '{1,   0,      0,   100,    200,  32767,  32767,   -50,    150,  50,     -150, 0};
        vecs[6] = '{0,   1000,   0,   500,    0,    32767,  0,       1500,   0,    500,    0,    0};
        vecs[7] = '{0,   32767,  0,   32767,  0,    32767,  0,       32767,  0,    1,      0,    1};
        vecs[8] = '{0,   -32768, 0,   32767,  0,    -32768, 0,       -32768, 0,    -1,     0,    1};
        vecs[9] = '{0,   0,      0,   1,      -1,   16384,  0,       1,      0,    -1,     0,    1};

        prev_sat[0] = 0;
        prev_sat[1] = 0;
        last_exp = '0;
        reset = 1'b0;
        vin1 = 1'b0;
        vin0 = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        for (int s = 0; s < 2; s++) begin
            sample(s, vo, r0, i0, r1, i1, fd, sat);
            chk($sformatf("reset_valid_%0d", s), vo, 0);
            chk($sformatf("reset_data_%0d", s), longint'(r0 | i0 | r1 | i1), 0);
            chk($sformatf("reset_frame_done_%0d", s), fd, 0);
            chk($sformatf("reset_sat_%0d", s), sat, 0);
        end

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        reset = 1'b0;
        tick();
        reset = 1'b1;
        run_frame(0, "frame_b2b");
        run_frame(2, "frame_cad3");

        // Move the counter off zero, then reset with two pairs still in flight.
        for (int p = 0; p < 5; p++) begin
            drive_rnd();
            vin1 = 1'b1;
            tick();
            vin1 = 1'b0;
            tick();
            tick();
        end
        repeat (4) tick();
        drive_rnd();
        vin1 = 1'b1;
        tick();
        drive_rnd();
        tick();
        vin1 = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("rst_flight_data", longint'({o1_r0, o1_i0, o1_r1, o1_i1}), 0);
        chk("rst_flight_sat", longint'(o1_sat), 0);
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("rst_flight_valid_c%0d", c), longint'(o1_v), 0);
            chk($sformatf("rst_flight_fd_c%0d", c), longint'(o1_fd), 0);
            tick();
        end
        run_frame(0, "frame_after_rst");

        for (int c = 0; c < 20; c++) begin
            drive_rnd();
            tick();
            chk($sformatf("idle_valid_c%0d", c), longint'(o1_v), 0);
            chk($sformatf("idle_fd_c%0d", c), longint'(o1_fd), 0);
            chk($sformatf("idle_hold_c%0d", c), longint'({o1_r0, o1_i0, o1_r1, o1_i1}), longint'(last_exp));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
